// File: rtl/adc_accumulator.sv
// rtl/adc_accumulator.sv - block accumulator for signed ADC samples with a captured result register
// Sums N = 2^N_LOG2 valid samples, then holds the sum and counts discarded samples until restarted.
module adc_accumulator #(
  parameter int DATA_W = 14,
  parameter int N_LOG2 = 10,
  parameter int ACC_W  = 32
) (
  input  logic                     adc_clk,
  input  logic                     RST,
  input  logic signed [DATA_W-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic                     ADC_RST,
  input  logic                     REG_WRITE,
  input  logic                     REG_RST,
  output logic                     done,
  output logic signed [ACC_W-1:0]  result,
  output logic                     result_valid,
  output logic [15:0]              dropped
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [N_LOG2:0] LAST = (N_LOG2+1)'((1 << N_LOG2) - 1);

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [N_LOG2:0]         count;
  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-DATA_W){adc_data[DATA_W-1]}}, adc_data};
  // done comes straight from the state flop, so it has no combinational path from adc_valid
  assign done = (state == HOLD);

  always_ff @(posedge adc_clk or posedge RST) begin
    if (RST) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
    end else if (ADC_RST) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
    end else if (state == ACCUM && adc_valid) begin
      acc   <= acc + sample_ext;
      count <= count + 1'b1;
      if (count == LAST) begin
        state <= HOLD;
      end
    end
  end

  // Result capture sees the pre-edge acc, so a simultaneous ADC_RST still captures the full block
  always_ff @(posedge adc_clk or posedge RST) begin
    if (RST) begin
      result       <= '0;
      result_valid <= 1'b0;
      dropped      <= '0;
    end else if (REG_RST) begin
      result       <= '0;
      result_valid <= 1'b0;
      dropped      <= '0;
    end else begin
      if (REG_WRITE) begin
        result       <= acc;
        result_valid <= 1'b1;
      end
      if (state == HOLD && adc_valid && !ADC_RST && dropped != 16'hFFFF) begin
        dropped <= dropped + 16'd1;
      end
    end
  end

endmodule
